iot_sequencer: RTL and testbench
================================

# iot_sequencer

Sequences one PDP-8 IOT instruction into timed IOP1/IOP2/IOP4 device strobes on the peripheral bus. Collects skip, read data and AC-clear responses from the selected device, and returns a merged AC value and skip flag to the CPU. It sits between the CPU execute state machine and the peripheral mux. It adds wait-state stretching and a timeout so slow devices (RK8E disk, serial) can share the same strobe path.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles one IOP phase may be stretched by io_wait (range 1–255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from CPU: IOT decoded, begin sequence
- instruction  in  [0:11]  current instruction; sampled only on accepted start
- ac  in  [0:11]  accumulator; sampled on accepted start
- io_wait  in  1  selected device stretches current IOP phase
- io_skip  in  1  device skip response
- io_data  in  [0:11]  device read data (0 when not driving)
- io_clr_ac  in  1  device requests AC clear before OR of io_data
- dev_sel  out  [0:5]  device code (instruction[3:8]), held for whole sequence
- iop1, iop2, iop4  out  1 each  phase strobes
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- ac_out  out  [0:11]  result AC, valid with done, held until next done
- skip_out  out  1  skip result, valid with done, held until next done
- timeout_err  out  1  sticky; set if any phase timed out, cleared on next accepted start

## Operation
- States: IDLE, P1, G1, P2, G2, P4, FIN.
- start is accepted only in IDLE when instruction[0:2]==3'b110. Other starts are ignored: no busy, no done.
- On accept:
  - latch instruction and ac; drive dev_sel; busy=1.
  - clear skip and timeout_err accumulators.
  - result := latched ac.
- Phase enables: bit11→IOP1, bit10→IOP2, bit9→IOP4. Order is fixed: 1, 2, 4.
- Disabled phases are skipped entirely and consume no cycles.
- Gap states (G1/G2) give one idle cycle between two enabled phases. There is no gap before the first phase or after the last.
- In a phase:
  - strobe high for ≥1 cycle; stays high while io_wait=1.
  - phase ends on the first cycle with io_wait=0, or after TIMEOUT cycles (timeout_err:=1, then proceed).
- Sampling, on the phase's final cycle only:
  - skip |= io_skip (any phase).
  - if io_clr_ac, result := 0 before merge.
  - result := result | io_data.
- FIN: done=1 one cycle; ac_out, skip_out updated; busy=0 on the following cycle; return to IDLE.
- No enabled phases (e.g. 6000 octal): go straight to FIN.
- A start arriving while busy is ignored. dev_sel, ac and instruction stay latched.
- Asserting reset mid-sequence:
  - all strobes drop immediately (async); state IDLE.
  - outputs return to reset values; no done.

## Timing
- Reset values: dev_sel=0, iop1/iop2/iop4=0, busy=0, done=0, ac_out=0, skip_out=0, timeout_err=0.
- All outputs are registered. Strobes change only on clk edges except at reset.
- Cycle 0 is the start cycle. busy is high from cycle 1 through the FIN cycle.
- Latency with no waits:
  - one phase: strobe at c1, done at c2.
  - two phases: c1, gap, c3, done at c4.
  - three phases: strobes at c1/c3/c5, done at c6.
  - none: done at c1.
- Each wait cycle adds one cycle. A timed-out phase lasts exactly TIMEOUT cycles.
- Strobes are mutually exclusive and never adjacent (gap guaranteed).

## Structure
- Shared package: state encoding, IOP bit positions (9/10/11), the IOT opcode constant 3'b110, and the default TIMEOUT.
- Sub-module iot_phase_timer:
  - counter cleared on phase entry.
  - outputs phase_end = !io_wait || count==TIMEOUT-1.
  - outputs timed_out.
- The sequencer FSM and result/skip accumulators stay in the top level.

## Test plan
- start, instruction=6031, io_skip=1 on IOP1 → iop1 at c1 only, done at c2, skip_out=1, ac_out=ac, dev_sel=03.
- instruction=6036, ac=7777, IOP2 with io_clr_ac=1, IOP4 with io_data=0101 → strobes at c1 and c3, done at c4, ac_out=0101, skip_out=0.
- instruction=6745, io_wait high 3 cycles in IOP1, io_data=0042 on IOP4 → iop1 lasts 4 cycles, done at c7, ac_out=ac|0042, timeout_err=0.
- TIMEOUT=16, io_wait stuck high, instruction=6741 → iop1 lasts exactly 16 cycles, done at c17, timeout_err=1. Next accepted start clears it.
- start with instruction=7300 → ignored: busy stays 0, no done. start at c2 of an in-progress 6036 → ignored, first sequence unchanged.
- reset asserted while iop2 high → iop2, busy and dev_sel drop to 0 immediately, no done. After release, start with 6004 → done at c2.

Source files
------------

// File: rtl/iot_sequencer_pkg.sv
// iot_sequencer_pkg
// Shared definitions for the PDP-8 IOT sequencer:
//   - FSM state encoding (IDLE, P1, G1, P2, G2, P4, FIN)
//   - instruction bit positions of the IOP1/IOP2/IOP4 enables
//   - IOT opcode value and default phase timeout
//   - phase-enable struct and a helper that picks the first phase state
// Instruction words use PDP-8 numbering: bit 0 is the MSB, bit 11 the LSB.
package iot_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P1   = 3'd1;
  localparam logic [2:0] ST_G1   = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_G2   = 3'd4;
  localparam logic [2:0] ST_P4   = 3'd5;
  localparam logic [2:0] ST_FIN  = 3'd6;

  localparam int IOP4_BIT = 9;
  localparam int IOP2_BIT = 10;
  localparam int IOP1_BIT = 11;

  localparam logic [0:2] IOT_OPCODE = 3'b110;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef struct packed {
    logic en1;
    logic en2;
    logic en4;
  } phase_en_t;

  // First state after an accepted start: the lowest enabled phase, or
  // straight to FIN when no phase is enabled.
  function automatic logic [2:0] first_state(input phase_en_t en);
    if (en.en1)      return ST_P1;
    else if (en.en2) return ST_P2;
    else if (en.en4) return ST_P4;
    else             return ST_FIN;
  endfunction

endpackage

// File: rtl/iot_phase_timer.sv
// iot_phase_timer
// Measures how long the current IOP phase has lasted and decides when it ends.
// Ports:
//   clk, reset   - system clock, asynchronous active-low reset
//   active       - sequencer is in a strobe phase (P1/P2/P4)
//   io_wait      - device asks to stretch the phase
//   phase_end    - this is the final cycle of the phase
//   timed_out    - phase is ending because the stretch limit was reached
module iot_phase_timer #(
  parameter int TIMEOUT = iot_sequencer_pkg::DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic io_wait,
  output logic phase_end,
  output logic timed_out
);

  logic [7:0] count;
  logic       at_limit;

  assign at_limit  = (count == 8'(TIMEOUT - 1));
  assign phase_end = active && (!io_wait || at_limit);
  assign timed_out = active && io_wait && at_limit;

  // Counter restarts at zero whenever a phase finishes, so the next phase
  // (always separated by a gap or idle cycle) starts from a clean count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (active && !phase_end) begin
      count <= count + 8'd1;
    end else begin
      count <= 8'd0;
    end
  end

endmodule

// File: rtl/iot_sequencer.sv
// iot_sequencer
// Turns one PDP-8 IOT instruction into timed IOP1/IOP2/IOP4 strobes, collects
// device responses and returns the merged AC and skip flag to the CPU.
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   start                 - one-cycle pulse: IOT decoded, begin sequence
//   instruction, ac       - sampled on an accepted start
//   io_wait               - device stretches the current phase
//   io_skip, io_data,
//   io_clr_ac             - device responses, sampled on a phase's last cycle
//   dev_sel               - device code, held from accept to next accept
//   iop1, iop2, iop4      - phase strobes
//   busy, done            - sequence in progress / one-cycle completion
//   ac_out, skip_out      - results, updated with done
//   timeout_err           - sticky phase-timeout flag, cleared on accept
module iot_sequencer #(
  parameter int TIMEOUT = iot_sequencer_pkg::DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:11] instruction,
  input  logic [0:11] ac,
  input  logic        io_wait,
  input  logic        io_skip,
  input  logic [0:11] io_data,
  input  logic        io_clr_ac,
  output logic [0:5]  dev_sel,
  output logic        iop1,
  output logic        iop2,
  output logic        iop4,
  output logic        busy,
  output logic        done,
  output logic [0:11] ac_out,
  output logic        skip_out,
  output logic        timeout_err
);

  import iot_sequencer_pkg::*;

  logic [2:0]  state;
  logic [2:0]  state_next;
  phase_en_t   en_q;
  phase_en_t   start_en;
  logic [0:11] result;
  logic [0:11] result_next;
  logic        skip_acc;
  logic        skip_next;
  logic        accept;
  logic        in_phase;
  logic        phase_end;
  logic        timed_out;

  assign start_en.en1 = instruction[IOP1_BIT];
  assign start_en.en2 = instruction[IOP2_BIT];
  assign start_en.en4 = instruction[IOP4_BIT];

  assign accept   = start && (state == ST_IDLE) && (instruction[0:2] == IOT_OPCODE);
  assign in_phase = (state == ST_P1) || (state == ST_P2) || (state == ST_P4);

  iot_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (in_phase),
    .io_wait   (io_wait),
    .phase_end (phase_end),
    .timed_out (timed_out)
  );

  // Next state and accumulator updates. A gap state is entered only when a
  // later phase is enabled, so the last phase falls straight into FIN.
  // G1 precedes P2, G2 precedes P4 (whether coming from P1 or P2).
  always_comb begin
    state_next  = state;
    result_next = result;
    skip_next   = skip_acc;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next  = first_state(start_en);
          result_next = ac;
          skip_next   = 1'b0;
        end
      end
      ST_P1: begin
        if (phase_end) begin
          if (en_q.en2)      state_next = ST_G1;
          else if (en_q.en4) state_next = ST_G2;
          else               state_next = ST_FIN;
        end
      end
      ST_G1: state_next = ST_P2;
      ST_P2: begin
        if (phase_end) state_next = en_q.en4 ? ST_G2 : ST_FIN;
      end
      ST_G2: state_next = ST_P4;
      ST_P4: begin
        if (phase_end) state_next = ST_FIN;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (in_phase && phase_end) begin
      skip_next   = skip_acc | io_skip;
      result_next = (io_clr_ac ? 12'd0 : result) | io_data;
    end
  end

  // Outputs are registered from the next state so strobes, busy and done
  // line up with the state they describe and never glitch between edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      en_q        <= '0;
      result      <= 12'd0;
      skip_acc    <= 1'b0;
      dev_sel     <= 6'd0;
      iop1        <= 1'b0;
      iop2        <= 1'b0;
      iop4        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ac_out      <= 12'd0;
      skip_out    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      result   <= result_next;
      skip_acc <= skip_next;
      iop1     <= (state_next == ST_P1);
      iop2     <= (state_next == ST_P2);
      iop4     <= (state_next == ST_P4);
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_FIN);
      if (accept) begin
        en_q        <= start_en;
        dev_sel     <= instruction[3:8];
        timeout_err <= 1'b0;
      end else if (timed_out) begin
        timeout_err <= 1'b1;
      end
      if (state_next == ST_FIN) begin
        ac_out   <= result_next;
        skip_out <= skip_next;
      end
    end
  end

endmodule

// File: tb/tb_iot_sequencer.sv
// tb_iot_sequencer
// Self-checking bench for iot_sequencer. A cycle-level schedule of expected
// strobes and the expected AC/skip/timeout results are computed from the
// instruction's phase enables and per-phase wait lengths, then compared with
// the DUT every cycle of each sequence.
module tb_iot_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] instruction;
  logic [11:0] ac;
  logic        io_wait;
  logic        io_skip;
  logic [11:0] io_data;
  logic        io_clr_ac;
  logic [5:0]  dev_sel;
  logic        iop1, iop2, iop4;
  logic        busy, done;
  logic [11:0] ac_out;
  logic        skip_out;
  logic        timeout_err;

  int n_compared;
  int n_mismatch;

  // Per-phase device behaviour, index 0 = IOP1, 1 = IOP2, 2 = IOP4.
  int          ph_wait [3];
  logic        ph_skip [3];
  logic        ph_clr  [3];
  logic [11:0] ph_data [3];
  int          len_of  [3];

  // Expected schedule indexed by cycle number relative to start.
  logic [2:0]  exp_strb [64];
  int          ph_at    [64];
  int          off_at   [64];

  iot_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .ac          (ac),
    .io_wait     (io_wait),
    .io_skip     (io_skip),
    .io_data     (io_data),
    .io_clr_ac   (io_clr_ac),
    .dev_sel     (dev_sel),
    .iop1        (iop1),
    .iop2        (iop2),
    .iop4        (iop4),
    .busy        (busy),
    .done        (done),
    .ac_out      (ac_out),
    .skip_out    (skip_out),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0o, expected %0o (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_phases();
    for (int p = 0; p < 3; p++) begin
      ph_wait[p] = 0;
      ph_skip[p] = 1'b0;
      ph_clr[p]  = 1'b0;
      ph_data[p] = 12'o0;
    end
  endtask

  task automatic drive_idle();
    start     = 1'b0;
    io_wait   = 1'b0;
    io_skip   = 1'b0;
    io_data   = 12'o0;
    io_clr_ac = 1'b0;
  endtask

  // Runs one accepted IOT. mid > 0 injects an (ignored) start on that cycle.
  task automatic applyStimulus(input logic [11:0] instr, input logic [11:0] acc, input int mid);
    logic [11:0] r;
    logic        s;
    logic        to;
    int          c;
    int          done_c;
    int          p;
    int          o;
    bit          first;
    for (int i = 0; i < 64; i++) begin
      exp_strb[i] = 3'b000;
      ph_at[i]    = -1;
      off_at[i]   = 0;
    end
    r = acc;
    s = 1'b0;
    to = 1'b0;
    c = 1;
    first = 1'b1;
    for (int q = 0; q < 3; q++) begin
      len_of[q] = 0;
      if (instr[q]) begin
        if (!first) c++;
        first = 1'b0;
        len_of[q] = (ph_wait[q] >= TIMEOUT) ? TIMEOUT : ph_wait[q] + 1;
        for (int k = 0; k < len_of[q]; k++) begin
          exp_strb[c] = 3'b100 >> q;
          ph_at[c]    = q;
          off_at[c]   = k;
          c++;
        end
        if (ph_clr[q]) r = 12'o0;
        r = r | ph_data[q];
        s = s | ph_skip[q];
        if (ph_wait[q] >= TIMEOUT) to = 1'b1;
      end
    end
    done_c = c;

    @(posedge clk); #1;
    drive_idle();
    start       = 1'b1;
    instruction = instr;
    ac          = acc;

    for (int cy = 1; cy <= done_c + 1; cy++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("c%0d strobes", cy), {iop1, iop2, iop4}, exp_strb[cy]);
      checkOutput($sformatf("c%0d busy", cy), busy, (cy <= done_c));
      checkOutput($sformatf("c%0d done", cy), done, (cy == done_c));
      if (cy == done_c) begin
        checkOutput("ac_out", ac_out, r);
        checkOutput("skip_out", skip_out, s);
        checkOutput("timeout_err", timeout_err, to);
        checkOutput("dev_sel", dev_sel, instr[8:3]);
      end
      if (cy == done_c + 1) begin
        checkOutput("ac_out_held", ac_out, r);
        checkOutput("timeout_err_sticky", timeout_err, to);
      end
      start       = (cy == mid) && (cy <= done_c);
      instruction = {3'b110, 9'($urandom)};
      ac          = 12'($urandom);
      if (ph_at[cy] >= 0) begin
        p = ph_at[cy];
        o = off_at[cy];
        io_wait = (o < ph_wait[p]);
        if (o == len_of[p] - 1) begin
          io_skip   = ph_skip[p];
          io_clr_ac = ph_clr[p];
          io_data   = ph_data[p];
        end else begin
          io_skip   = 1'($urandom);
          io_clr_ac = 1'($urandom);
          io_data   = 12'($urandom);
        end
      end else begin
        io_wait   = 1'($urandom);
        io_skip   = 1'($urandom);
        io_clr_ac = 1'($urandom);
        io_data   = 12'($urandom);
      end
    end
    drive_idle();
  endtask

  task automatic check_ignored_start(input logic [11:0] instr);
    @(posedge clk); #1;
    drive_idle();
    start       = 1'b1;
    instruction = instr;
    for (int cy = 1; cy <= 3; cy++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput($sformatf("ign c%0d busy", cy), busy, 1'b0);
      checkOutput($sformatf("ign c%0d done", cy), done, 1'b0);
      checkOutput($sformatf("ign c%0d strobes", cy), {iop1, iop2, iop4}, 3'b000);
    end
  endtask

  initial begin
    int r;
    n_compared = 0;
    n_mismatch = 0;
    reset = 1'b0;
    instruction = 12'o0;
    ac = 12'o0;
    drive_idle();
    clear_phases();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst dev_sel", dev_sel, 6'o00);
    checkOutput("rst strobes", {iop1, iop2, iop4}, 3'b000);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst done", done, 1'b0);
    checkOutput("rst ac_out", ac_out, 12'o0);
    checkOutput("rst skip_out", skip_out, 1'b0);
    checkOutput("rst timeout_err", timeout_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Single IOP1 with skip.
    clear_phases();
    ph_skip[0] = 1'b1;
    applyStimulus(12'o6031, 12'o1234, 0);

    // AC clear on IOP2 then OR on IOP4, with an ignored start at c2.
    clear_phases();
    ph_clr[1]  = 1'b1;
    ph_data[2] = 12'o0101;
    applyStimulus(12'o6036, 12'o7777, 2);

    // Three wait cycles on IOP1, data on IOP4.
    clear_phases();
    ph_wait[0] = 3;
    ph_data[2] = 12'o0042;
    applyStimulus(12'o6745, 12'o1200, 0);

    // Stuck wait: timeout after exactly TIMEOUT cycles.
    clear_phases();
    ph_wait[0] = 100;
    applyStimulus(12'o6741, 12'o0007, 0);

    // Next accepted start clears the sticky timeout.
    clear_phases();
    applyStimulus(12'o6031, 12'o0550, 0);

    // Wait released on the last allowed cycle: full length, no timeout.
    clear_phases();
    ph_wait[0] = TIMEOUT - 1;
    ph_data[0] = 12'o3000;
    applyStimulus(12'o6001, 12'o0011, 0);

    // No enabled phases.
    clear_phases();
    applyStimulus(12'o6000, 12'o4321, 0);

    // Non-IOT start is ignored.
    check_ignored_start(12'o7300);

    // Reset while iop2 is high.
    @(posedge clk); #1;
    drive_idle();
    start       = 1'b1;
    instruction = 12'o6036;
    ac          = 12'o1111;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("pre-reset iop2", iop2, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async rst strobes", {iop1, iop2, iop4}, 3'b000);
    checkOutput("async rst busy", busy, 1'b0);
    checkOutput("async rst dev_sel", dev_sel, 6'o00);
    checkOutput("async rst ac_out", ac_out, 12'o0);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("in rst done", done, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post rst done", done, 1'b0);
    checkOutput("post rst busy", busy, 1'b0);
    clear_phases();
    applyStimulus(12'o6004, 12'o0123, 0);

    // Randomized sequences.
    for (int n = 0; n < 40; n++) begin
      clear_phases();
      for (int p = 0; p < 3; p++) begin
        r = $urandom_range(0, 99);
        if (r < 65)      ph_wait[p] = 0;
        else if (r < 88) ph_wait[p] = $urandom_range(1, 4);
        else             ph_wait[p] = $urandom_range(TIMEOUT - 2, TIMEOUT + 3);
        ph_skip[p] = 1'($urandom);
        ph_clr[p]  = ($urandom_range(0, 3) == 0);
        ph_data[p] = 12'($urandom);
      end
      applyStimulus({3'b110, 9'($urandom)}, 12'($urandom), $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
